// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared types and constants for the ID/EX pipeline stage.
package id_ex_pkg;
    localparam int XLEN_D     = 32;
    localparam int PC_W_D     = 32;
    localparam int REG_AW_D   = 5;
    localparam int ALU_OP_W_D = 4;

    typedef struct packed {
        logic                  mem_reg;
        logic                  reg_en;
        logic                  alu_src;
        logic [ALU_OP_W_D-1:0] alu_op;
        logic                  m_rd_en;
        logic                  m_wr_en;
    } ctrl_t;

    typedef struct packed {
        ctrl_t                 ctrl;
        logic [REG_AW_D-1:0]   rs1_addr;
        logic [REG_AW_D-1:0]   rs2_addr;
        logic [REG_AW_D-1:0]   rd_addr;
        logic [XLEN_D-1:0]     rs1_data;
        logic [XLEN_D-1:0]     rs2_data;
        logic [XLEN_D-1:0]     imm;
        logic [PC_W_D-1:0]     pc;
    } payload_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic int ctrl_w(int alu_op_w);
        return alu_op_w + 5;
    endfunction
endpackage

// File: rtl/id_ex_skid_slot.sv
// id_ex_skid_slot: one payload register plus valid flag; clearing zeroes the
// control field (top CW bits) so an empty slot can never issue side effects.
module id_ex_skid_slot
    import id_ex_pkg::*;
#(
    parameter int W  = $bits(payload_t),
    parameter int CW = $bits(ctrl_t)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q,
    output logic         o_v
);
    logic [W-1:0] r_q;
    logic         r_v;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
            r_v <= 1'b0;
        end else if (i_clear) begin
            r_v           <= 1'b0;
            r_q[W-1 -: CW] <= '0;
        end else if (i_load) begin
            r_q <= i_d;
            r_v <= 1'b1;
        end
    end

    assign o_q = r_q;
    assign o_v = r_v;
endmodule

// File: rtl/id_ex_pipe_stage.sv
// id_ex_pipe_stage: ID/EX register with valid/ready handshake, main+skid
// entries (registered in_ready), synchronous flush and saturating stall count.
module id_ex_pipe_stage
    import id_ex_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int PC_W     = 32,
    parameter int REG_AW   = 5,
    parameter int ALU_OP_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic                CLK,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic                mem_reg_i,
    input  logic                reg_en_i,
    input  logic                alu_src_i,
    input  logic                m_rd_en_i,
    input  logic                m_wr_en_i,
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [REG_AW-1:0]   rs1_addr_i,
    input  logic [REG_AW-1:0]   rs2_addr_i,
    input  logic [REG_AW-1:0]   rd_addr_i,
    input  logic [XLEN-1:0]     rs1_data_i,
    input  logic [XLEN-1:0]     rs2_data_i,
    input  logic [XLEN-1:0]     imm_i,
    input  logic [PC_W-1:0]     pc_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic                mem_reg_o,
    output logic                reg_en_o,
    output logic                alu_src_o,
    output logic                m_rd_en_o,
    output logic                m_wr_en_o,
    output logic [ALU_OP_W-1:0] alu_op_o,
    output logic [REG_AW-1:0]   rs1_addr_o,
    output logic [REG_AW-1:0]   rs2_addr_o,
    output logic [REG_AW-1:0]   rd_addr_o,
    output logic [XLEN-1:0]     rs1_data_o,
    output logic [XLEN-1:0]     rs2_data_o,
    output logic [XLEN-1:0]     imm_o,
    output logic [PC_W-1:0]     pc_o,
    output logic [CNT_W-1:0]    stall_cnt_o
);
    localparam int CW = ctrl_w(ALU_OP_W);
    localparam int PW = CW + 3*REG_AW + 3*XLEN + PC_W;

    logic [PW-1:0]    w_in, w_m_d, w_m_q, w_s_q;
    logic             w_m_v, w_s_v, w_acc, w_pop;
    logic             w_m_load, w_m_clear, w_s_load, w_s_clear;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_in = {mem_reg_i, reg_en_i, alu_src_i, alu_op_i, m_rd_en_i, m_wr_en_i,
                   rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_data_i, rs2_data_i, imm_i, pc_i};

    // in_ready is the inverted skid valid flop: no path from out_ready_i
    assign in_ready_o = ~w_s_v;
    assign w_acc      = in_valid_i & in_ready_o;
    assign w_pop      = w_m_v & out_ready_i;

    assign w_m_load  = ~flush_i & ((~w_m_v & w_acc) | (w_pop & (w_s_v | w_acc)));
    assign w_m_clear = flush_i | (w_pop & ~w_s_v & ~w_acc);
    assign w_m_d     = (w_pop & w_s_v) ? w_s_q : w_in;
    assign w_s_load  = ~flush_i & w_m_v & ~w_pop & w_acc;
    assign w_s_clear = flush_i | (w_pop & w_s_v);

    id_ex_skid_slot #(.W(PW), .CW(CW)) u_main (
        .i_clk  (CLK),
        .i_rst_n(rst_n),
        .i_load (w_m_load),
        .i_clear(w_m_clear),
        .i_d    (w_m_d),
        .o_q    (w_m_q),
        .o_v    (w_m_v)
    );

    id_ex_skid_slot #(.W(PW), .CW(CW)) u_skid (
        .i_clk  (CLK),
        .i_rst_n(rst_n),
        .i_load (w_s_load),
        .i_clear(w_s_clear),
        .i_d    (w_in),
        .o_q    (w_s_q),
        .o_v    (w_s_v)
    );

    always_ff @(posedge CLK) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_m_v & ~out_ready_i & ~&r_stall_cnt)
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign out_valid_o = w_m_v;
    assign stall_cnt_o = r_stall_cnt;
    assign {mem_reg_o, reg_en_o, alu_src_o, alu_op_o, m_rd_en_o, m_wr_en_o,
            rs1_addr_o, rs2_addr_o, rd_addr_o, rs1_data_o, rs2_data_o, imm_o, pc_o} = w_m_q;
endmodule
